// File: rtl/bp_pkg.sv
// Shared constants and types for the tagged branch target buffer.
// Counter encoding runs from strongly not-taken (00) up to strongly taken (11).
package bp_pkg;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    localparam int MODE_SAT  = 0;
    localparam int MODE_HYST = 1;

    // Control bits of a resolved instruction; PC-width fields stay as
    // separate ports because their width is a per-instance parameter.
    typedef struct packed {
        logic valid;
        logic is_jump;
        logic taken;
        logic pred_taken;
    } bp_upd_t;

endpackage

// File: rtl/bp_counter.sv
// Next-state function of one 2-bit direction counter.
// An unconditional jump always lands on strongly taken, whatever the policy.
module bp_counter
    import bp_pkg::*;
#(
    parameter int MODE = MODE_SAT
) (
    input  logic [1:0] ctr,
    input  logic       taken,
    input  logic       is_jump,
    output logic [1:0] ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (is_jump) begin
            ctr_next = CTR_ST;
        end else if (MODE == MODE_HYST) begin
            // Hysteresis: a single wrong outcome from a strong state only weakens it,
            // while any other wrong outcome jumps straight to the opposite strong state.
            if (taken) begin
                ctr_next = (ctr == CTR_SNT) ? CTR_WNT : CTR_ST;
            end else begin
                ctr_next = (ctr == CTR_ST) ? CTR_WT : CTR_SNT;
            end
        end else begin
            if (taken) begin
                ctr_next = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
            end else begin
                ctr_next = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped tagged branch target buffer with a per-entry direction counter.
// Combinational lookup for fetch, clocked update from branch resolution, saturating stats.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int PC_W   = 16,
    parameter int IDX_W  = 6,
    parameter int MODE   = MODE_SAT,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              upd_valid,
    input  logic [PC_W-1:0]   upd_pc,
    input  logic              upd_is_jump,
    input  logic              upd_taken,
    input  logic [PC_W-1:0]   upd_target,
    input  logic              upd_pred_taken,
    input  logic [PC_W-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    input  logic              flush_all,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_updates,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0] valid_reg;
    logic [ENTRIES-1:0] jump_reg;
    logic [1:0]         ctr_reg    [ENTRIES];
    logic [TAG_W-1:0]   tag_reg    [ENTRIES];
    logic [PC_W-1:0]    target_reg [ENTRIES];

    logic [STAT_W-1:0]  stat_updates_reg;
    logic [STAT_W-1:0]  stat_mispredicts_reg;

    bp_upd_t            upd;
    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               upd_hit;
    logic               wr_hit;
    logic               wr_alloc;
    logic               wr_target;
    logic [1:0]         ctr_next;
    logic [ENTRIES-1:0] sel_vec;

    assign upd = '{valid: upd_valid, is_jump: upd_is_jump,
                   taken: upd_taken, pred_taken: upd_pred_taken};

    // Lookup path: tag and target are only meaningful behind a set valid bit.
    assign lk_idx      = lookup_pc[IDX_W-1:0];
    assign lk_tag      = lookup_pc[PC_W-1:IDX_W];
    assign pred_hit    = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && (jump_reg[lk_idx] || ctr_reg[lk_idx][1]);
    assign pred_target = pred_taken ? target_reg[lk_idx] : lookup_pc + PC_W'(1);

    assign mispredict  = upd.valid &&
                         ((upd.taken != upd.pred_taken) ||
                          (upd.taken && (upd_target != upd_pred_target)));
    assign redirect_pc = upd.taken ? upd_target : upd_pc + PC_W'(1);

    // Update path: a flush in the same cycle drops the table write entirely.
    assign up_idx    = upd_pc[IDX_W-1:0];
    assign up_tag    = upd_pc[PC_W-1:IDX_W];
    assign upd_hit   = valid_reg[up_idx] && (tag_reg[up_idx] == up_tag);
    assign wr_hit    = upd.valid && !flush_all && upd_hit;
    assign wr_alloc  = upd.valid && !flush_all && !upd_hit && upd.taken;
    assign wr_target = wr_alloc || (wr_hit && upd.taken);

    bp_counter #(
        .MODE (MODE)
    ) u_counter (
        .ctr      (ctr_reg[up_idx]),
        .taken    (upd.taken),
        .is_jump  (upd.is_jump),
        .ctr_next (ctr_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
            jump_reg  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_reg[i] <= CTR_SNT;
            end
        end else if (flush_all) begin
            valid_reg <= '0;
        end else if (wr_hit) begin
            ctr_reg[up_idx]  <= ctr_next;
            jump_reg[up_idx] <= upd.is_jump;
        end else if (wr_alloc) begin
            valid_reg[up_idx] <= 1'b1;
            ctr_reg[up_idx]   <= CTR_WT;
            jump_reg[up_idx]  <= upd.is_jump;
        end
    end

    // Tag and target storage carries no reset; each entry loads on its own enable.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            assign sel_vec[gi] = (up_idx == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (sel_vec[gi] && wr_alloc) begin
                    tag_reg[gi] <= up_tag;
                end
                if (sel_vec[gi] && wr_target) begin
                    target_reg[gi] <= upd_target;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_updates_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else if (stat_clr) begin
            stat_updates_reg     <= '0;
            stat_mispredicts_reg <= '0;
        end else begin
            if (upd.valid && (stat_updates_reg != STAT_MAX)) begin
                stat_updates_reg <= stat_updates_reg + STAT_W'(1);
            end
            if (mispredict && (stat_mispredicts_reg != STAT_MAX)) begin
                stat_mispredicts_reg <= stat_mispredicts_reg + STAT_W'(1);
            end
        end
    end

    assign stat_updates     = stat_updates_reg;
    assign stat_mispredicts = stat_mispredicts_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: a saturating/16-bit-stat instance and a hysteresis/4-bit-stat
// instance share stimulus and are compared against a per-entry table model.
module tb_branch_predictor;
    import bp_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [15:0] lookup_pc, upd_pc, upd_target, upd_pred_target;
    logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken, flush_all, stat_clr;

    logic        d0_hit, d0_taken, d0_mis, d1_hit, d1_taken, d1_mis;
    logic [15:0] d0_target, d0_redir, d1_target, d1_redir;
    logic [15:0] d0_su, d0_sm;
    logic [3:0]  d1_su, d1_sm;

    branch_predictor #(.PC_W(16), .IDX_W(6), .MODE(MODE_SAT), .STAT_W(16)) dut0 (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(d0_hit), .pred_taken(d0_taken), .pred_target(d0_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(d0_mis), .redirect_pc(d0_redir), .flush_all(flush_all),
        .stat_clr(stat_clr), .stat_updates(d0_su), .stat_mispredicts(d0_sm));

    branch_predictor #(.PC_W(16), .IDX_W(6), .MODE(MODE_HYST), .STAT_W(4)) dut1 (
        .clk(clk), .reset(reset), .lookup_pc(lookup_pc),
        .pred_hit(d1_hit), .pred_taken(d1_taken), .pred_target(d1_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(d1_mis), .redirect_pc(d1_redir), .flush_all(flush_all),
        .stat_clr(stat_clr), .stat_updates(d1_su), .stat_mispredicts(d1_sm));

    typedef struct {
        int hit; int taken; int target; int mis; int redir; int su; int sm;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int checks = 0;
    int failures = 0;
    int txn = 0;

    // Reference model: one record per table entry, counters as plain integers 0..3.
    bit mv   [2][64];
    bit mjmp [2][64];
    int mtag [2][64];
    int mtgt [2][64];
    int mctr [2][64];
    int msu  [2];
    int msm  [2];
    int smax  [2] = '{65535, 15};
    int mmode [2] = '{0, 1};

    function automatic int step(int mode, int c, bit t, bit j);
        if (j) return 3;
        if (mode == 1) return t ? ((c == 0) ? 1 : 3) : ((c == 3) ? 2 : 0);
        return t ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
    endfunction

    task automatic model_reset(input int m);
        for (int i = 0; i < 64; i++) begin
            mv[m][i] = 0; mctr[m][i] = 0; mjmp[m][i] = 0;
        end
        msu[m] = 0; msm[m] = 0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s txn=%0d actual=%0h expected=%0h", name, txn, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input int lpc, input bit uv, input int upc,
                         input bit uj, input bit ut, input int utg, input bit upt,
                         input int uptg, input bit fl, input bit sc);
        exp_t e;
        int li, lt, ui, utag;
        bit mis, hit;
        @(posedge clk);
        #1;
        reset = rst; lookup_pc = 16'(lpc); upd_valid = uv; upd_pc = 16'(upc);
        upd_is_jump = uj; upd_taken = ut; upd_target = 16'(utg);
        upd_pred_taken = upt; upd_pred_target = 16'(uptg); flush_all = fl; stat_clr = sc;
        li = lpc % 64; lt = lpc / 64; ui = upc % 64; utag = upc / 64;
        mis = uv && ((ut != upt) || (ut && (utg != uptg)));
        for (int m = 0; m < 2; m++) begin
            if (rst) model_reset(m);
            e.hit    = (mv[m][li] && (mtag[m][li] == lt)) ? 1 : 0;
            e.taken  = (e.hit == 1 && (mjmp[m][li] || mctr[m][li] >= 2)) ? 1 : 0;
            e.target = (e.taken == 1) ? mtgt[m][li] : (lpc + 1) % 65536;
            e.mis    = mis ? 1 : 0;
            e.redir  = ut ? utg : (upc + 1) % 65536;
            e.su     = msu[m];
            e.sm     = msm[m];
            if (m == 0) q0.push_back(e); else q1.push_back(e);
            if (!rst) begin
                if (sc) begin
                    msu[m] = 0; msm[m] = 0;
                end else begin
                    if (uv && msu[m] < smax[m]) msu[m]++;
                    if (mis && msm[m] < smax[m]) msm[m]++;
                end
                if (fl) begin
                    for (int i = 0; i < 64; i++) mv[m][i] = 0;
                end else if (uv) begin
                    hit = mv[m][ui] && (mtag[m][ui] == utag);
                    if (hit) begin
                        mctr[m][ui] = step(mmode[m], mctr[m][ui], ut, uj);
                        if (ut) mtgt[m][ui] = utg;
                        mjmp[m][ui] = uj;
                    end else if (ut) begin
                        mv[m][ui] = 1; mtag[m][ui] = utag; mtgt[m][ui] = utg;
                        mjmp[m][ui] = uj; mctr[m][ui] = 2;
                    end
                end
            end
        end
    endtask

    task automatic idle(input int lpc);
        drive(0, lpc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input int lpc, input int upc, input bit uj, input bit ut,
                           input int utg, input bit upt, input int uptg);
        drive(0, lpc, 1, upc, uj, ut, utg, upt, uptg, 0, 0);
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents one response.
    exp_t e0, e1;
    always @(negedge clk) begin
        if (q0.size() > 0 && q1.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            chk("d0_hit",    int'(d0_hit),    e0.hit);
            chk("d0_taken",  int'(d0_taken),  e0.taken);
            chk("d0_target", int'(d0_target), e0.target);
            chk("d0_mis",    int'(d0_mis),    e0.mis);
            chk("d0_redir",  int'(d0_redir),  e0.redir);
            chk("d0_su",     int'(d0_su),     e0.su);
            chk("d0_sm",     int'(d0_sm),     e0.sm);
            chk("d1_hit",    int'(d1_hit),    e1.hit);
            chk("d1_taken",  int'(d1_taken),  e1.taken);
            chk("d1_target", int'(d1_target), e1.target);
            chk("d1_mis",    int'(d1_mis),    e1.mis);
            chk("d1_redir",  int'(d1_redir),  e1.redir);
            chk("d1_su",     int'(d1_su),     e1.su);
            chk("d1_sm",     int'(d1_sm),     e1.sm);
            $display("txn %0d rst=%0b lpc=%04h hit=%0b/%0b tk=%0b/%0b tgt=%04h/%04h mis=%0b redir=%04h su=%0d/%0d sm=%0d/%0d",
                     txn, reset, lookup_pc, d0_hit, d1_hit, d0_taken, d1_taken, d0_target,
                     d1_target, d0_mis, d0_redir, d0_su, d1_su, d0_sm, d1_sm);
            txn++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, lpc, upc, utg, uptg, w;
        bit rst, fl, sc, uv, uj, ut, upt;
        reset = 1'b1; lookup_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0;
        upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        flush_all = 1'b0; stat_clr = 1'b0;
        for (int m = 0; m < 2; m++) model_reset(m);

        drive(1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Cold start: miss, allocate with same-cycle lookup seeing old data, then hit.
        idle('h40);
        resolve('h40, 'h40, 0, 1, 'h100, 0, 'h41);
        idle('h40);
        // Counter walk on the allocated entry.
        resolve('h40, 'h40, 0, 0, 'h100, 1, 'h100);
        resolve('h40, 'h40, 0, 0, 'h100, 0, 'h41);
        resolve('h40, 'h40, 0, 0, 'h100, 0, 'h41);
        resolve('h40, 'h40, 0, 1, 'h100, 0, 'h41);
        idle('h40);
        // Aliasing at index 0.
        resolve('h1040, 'h1040, 0, 1, 'h2000, 0, 'h1041);
        idle('h40);
        resolve('h40, 'h40, 0, 0, 'h100, 0, 'h41);
        idle('h1040);
        // Jump allocation, then strong-taken walk down for both policies.
        resolve('h80, 'h80, 1, 1, 'h300, 0, 'h81);
        resolve('h80, 'h80, 0, 1, 'h300, 1, 'h300);
        resolve('h80, 'h80, 0, 0, 'h300, 1, 'h300);
        idle('h80);
        resolve('h80, 'h80, 0, 0, 'h300, 1, 'h300);
        idle('h80);
        resolve('h80, 'h80, 0, 1, 'h304, 0, 'h81);
        idle('h80);
        // PC wrap at the top of the address space.
        idle('hFFFF);
        resolve('hFFFF, 'hFFFF, 0, 0, 0, 0, 0);
        // Flush together with an update.
        drive(0, 'h40, 1, 'hC0, 0, 1, 'h500, 0, 'hC1, 1, 0);
        idle('h1040);
        idle('hC0);
        // Drive the mispredict counters past the 4-bit ceiling.
        for (int i = 0; i < 20; i++) resolve('h300, 'h300 + i, 0, 1, 'h200, 0, 'h200);
        idle('h300);
        drive(0, 'h300, 1, 'h300, 0, 1, 'h200, 0, 'h200, 0, 1);
        idle('h300);
        // Reset asserted between edges with live table contents.
        resolve('h40, 'h40, 0, 1, 'h700, 0, 'h41);
        idle('h40);
        drive(1, 'h40, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle('h40);

        for (int n = 0; n < 400; n++) begin
            r    = int'($urandom_range(0, 99));
            rst  = (r == 0);
            fl   = (r >= 1 && r <= 3);
            sc   = (r >= 4 && r <= 6);
            lpc  = int'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            upc  = int'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
            uv   = !rst && ($urandom_range(0, 3) != 0);
            uj   = ($urandom_range(0, 7) == 0);
            ut   = uj || ($urandom_range(0, 1) == 1);
            utg  = int'('h100 * $urandom_range(1, 4));
            upt  = ($urandom_range(0, 1) == 1);
            uptg = ($urandom_range(0, 1) == 1) ? utg : int'('h100 * $urandom_range(1, 4));
            drive(rst, lpc, uv, upc, uj, ut, utg, upt, uptg, fl, sc);
        end
        idle(0);

        w = 0;
        while ((q0.size() != 0 || q1.size() != 0) && w < 20) begin
            @(posedge clk);
            w++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", q0.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
